// File: rtl/code_lock_pkg.sv
// Shared types and constants for the programmable code lock.
package code_lock_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        PROG     = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    localparam int unsigned LEVEL_W   = 2;
    localparam int unsigned MAX_SHIFT = 3;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/code_lock_entry.sv
// Digit shift buffer and index counter; done strobes with the full code on the CODE_LEN-th digit.
module code_lock_entry
    import code_lock_pkg::*;
#(
    parameter int unsigned CODE_LEN = 4,
    parameter int unsigned DIGIT_W  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear_i,
    input  logic                        valid_i,
    input  logic [DIGIT_W-1:0]          digit_i,
    output logic                        done_o,
    output logic [CODE_LEN*DIGIT_W-1:0] code_o
);

    localparam int unsigned CW    = CODE_LEN * DIGIT_W;
    localparam int unsigned IDX_W = clog2_min1(CODE_LEN);

    logic [CW-1:0]    buf_q, buf_d, shifted;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last;

    always_comb begin
        // Oldest digit drops off the top, so the first digit ends up in the MSBs.
        shifted = CW'({buf_q, digit_i});
        last    = (idx_q == IDX_W'(CODE_LEN - 1));
        done_o  = valid_i && !clear_i && last;
        code_o  = shifted;
        buf_d   = buf_q;
        idx_d   = idx_q;
        if (clear_i) begin
            buf_d = '0;
            idx_d = '0;
        end else if (valid_i) begin
            buf_d = shifted;
            idx_d = last ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            idx_q <= '0;
        end else begin
            buf_q <= buf_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/code_lock_prog.sv
// Programmable keypad code lock with lockout and optional auto-relock.
// Optional escalating lockout enabled by defining CODE_LOCK_ESCALATE_EN.
module code_lock_prog
    import code_lock_pkg::*;
#(
    parameter int unsigned CODE_LEN           = 4,
    parameter int unsigned DIGIT_W            = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
    parameter int unsigned MAX_ATTEMPTS       = 3,
    parameter int unsigned LOCKOUT_CYCLES     = 1000,
    parameter int unsigned AUTO_RELOCK_CYCLES = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DIGIT_W-1:0]                  digit,
    input  logic                                valid,
    input  logic                                relock,
    input  logic                                prog_start,
    output logic                                unlocked,
    output logic                                prog_mode,
    output logic                                wrong_try_pulse,
    output logic                                prog_done_pulse,
    output logic                                lockout,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   fail_count
);

    localparam int unsigned CW       = CODE_LEN * DIGIT_W;
    localparam int unsigned FC_W     = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned LOCK_MAX = LOCKOUT_CYCLES << MAX_SHIFT;
    localparam int unsigned TMR_MAX  = (LOCK_MAX > AUTO_RELOCK_CYCLES) ? LOCK_MAX : AUTO_RELOCK_CYCLES;
    localparam int unsigned TMR_W    = clog2_min1(TMR_MAX + 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     code_q, code_d;
    logic [FC_W-1:0]   fail_q, fail_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d, lock_len;
    logic              wrong_q, wrong_d;
    logic              pdone_q, pdone_d;
    logic              unl_q, pm_q, lo_q;
    logic              entry_active, entry_valid, entry_clear, entry_done;
    logic [CW-1:0]     entry_code;
`ifdef CODE_LOCK_ESCALATE_EN
    logic [LEVEL_W-1:0] level_q, level_d;
`endif

    assign entry_active = (state_q == LOCKED) || (state_q == PROG);
    assign entry_valid  = valid && !relock && entry_active;
    assign entry_clear  = relock || !entry_active;

    code_lock_entry #(
        .CODE_LEN (CODE_LEN),
        .DIGIT_W  (DIGIT_W)
    ) u_entry (
        .clk     (clk),
        .rst     (rst),
        .clear_i (entry_clear),
        .valid_i (entry_valid),
        .digit_i (digit),
        .done_o  (entry_done),
        .code_o  (entry_code)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        fail_d  = fail_q;
        tmr_d   = tmr_q;
        wrong_d = 1'b0;
        pdone_d = 1'b0;
`ifdef CODE_LOCK_ESCALATE_EN
        level_d  = level_q;
        lock_len = TMR_W'(LOCKOUT_CYCLES) << level_q;
`else
        lock_len = TMR_W'(LOCKOUT_CYCLES);
`endif
        // Timers load length-1 on entry and leave the state on the cycle they read zero.
        case (state_q)
            LOCKED: begin
                if (entry_done) begin
                    if (entry_code == code_q) begin
                        state_d = UNLOCKED;
                        fail_d  = '0;
                        tmr_d   = TMR_W'(AUTO_RELOCK_CYCLES - 1);
`ifdef CODE_LOCK_ESCALATE_EN
                        level_d = '0;
`endif
                    end else begin
                        wrong_d = 1'b1;
                        fail_d  = fail_q + 1'b1;
                        if (fail_q == FC_W'(MAX_ATTEMPTS - 1)) begin
                            state_d = LOCKOUT;
                            tmr_d   = lock_len - 1'b1;
`ifdef CODE_LOCK_ESCALATE_EN
                            if (level_q != LEVEL_W'(MAX_SHIFT))
                                level_d = level_q + 1'b1;
`endif
                        end
                    end
                end
            end
            UNLOCKED: begin
                if (relock) begin
                    state_d = LOCKED;
                end else if (AUTO_RELOCK_CYCLES != 0 && tmr_q == '0) begin
                    state_d = LOCKED;
                end else if (prog_start) begin
                    state_d = PROG;
                end else if (AUTO_RELOCK_CYCLES != 0) begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            PROG: begin
                if (relock) begin
                    state_d = LOCKED;
                end else if (entry_done) begin
                    code_d  = entry_code;
                    pdone_d = 1'b1;
                    state_d = UNLOCKED;
                    tmr_d   = TMR_W'(AUTO_RELOCK_CYCLES - 1);
                end
            end
            LOCKOUT: begin
                if (tmr_q == '0) begin
                    state_d = LOCKED;
                    fail_d  = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = LOCKED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOCKED;
            code_q  <= DEFAULT_CODE;
            fail_q  <= '0;
            tmr_q   <= '0;
            wrong_q <= 1'b0;
            pdone_q <= 1'b0;
            unl_q   <= 1'b0;
            pm_q    <= 1'b0;
            lo_q    <= 1'b0;
`ifdef CODE_LOCK_ESCALATE_EN
            level_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            fail_q  <= fail_d;
            tmr_q   <= tmr_d;
            wrong_q <= wrong_d;
            pdone_q <= pdone_d;
            unl_q   <= (state_d == UNLOCKED) || (state_d == PROG);
            pm_q    <= (state_d == PROG);
            lo_q    <= (state_d == LOCKOUT);
`ifdef CODE_LOCK_ESCALATE_EN
            level_q <= level_d;
`endif
        end
    end

    assign unlocked        = unl_q;
    assign prog_mode       = pm_q;
    assign wrong_try_pulse = wrong_q;
    assign prog_done_pulse = pdone_q;
    assign lockout         = lo_q;
    assign fail_count      = fail_q;

endmodule

// File: tb/tb_code_lock_prog.sv
// Directed vector bench for code_lock_prog (LOCKOUT_CYCLES=80, AUTO_RELOCK_CYCLES=50).
module tb_code_lock_prog;

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       rl;
        logic       ps;
        logic [6:0] exp;  // {unlocked, wrong, prog_mode, prog_done, lockout, fail_count[1:0]}
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digit = '0;
    logic       valid = 1'b0;
    logic       relock = 1'b0;
    logic       prog_start = 1'b0;
    logic       unlocked, prog_mode, wrong_try_pulse, prog_done_pulse, lockout;
    logic [1:0] fail_count;

    int total = 0;
    int bad   = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    code_lock_prog #(
        .CODE_LEN           (4),
        .DIGIT_W            (4),
        .DEFAULT_CODE       (16'h1234),
        .MAX_ATTEMPTS       (3),
        .LOCKOUT_CYCLES     (80),
        .AUTO_RELOCK_CYCLES (50)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .digit           (digit),
        .valid           (valid),
        .relock          (relock),
        .prog_start      (prog_start),
        .unlocked        (unlocked),
        .prog_mode       (prog_mode),
        .wrong_try_pulse (wrong_try_pulse),
        .prog_done_pulse (prog_done_pulse),
        .lockout         (lockout),
        .fail_count      (fail_count)
    );

    function automatic vec_t mk(input logic v, input logic [3:0] d, input logic rl, input logic ps,
                                input logic unl, input logic wr, input logic pm, input logic pd,
                                input logic lo, input logic [1:0] fc);
        vec_t r;
        r.v = v; r.d = d; r.rl = rl; r.ps = ps;
        r.exp = {unl, wr, pm, pd, lo, fc};
        return r;
    endfunction

    function automatic int exp_lock_len(input int k);
`ifdef CODE_LOCK_ESCALATE_EN
        return 80 << ((k > 3) ? 3 : k);
`else
        return 80 + 0 * k;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] outs();
        return {unlocked, wrong_try_pulse, prog_mode, prog_done_pulse, lockout, fail_count};
    endfunction

    task automatic enter4(input logic [15:0] c);
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            digit = c[15-4*i -: 4];
            tick();
        end
        valid = 1'b0;
    endtask

    // Adds four digit vectors; only the last carries the result outputs.
    task automatic add4(input logic [15:0] c, input logic [6:0] mid, input logic [6:0] fin);
        vec_t t;
        for (int i = 0; i < 4; i++) begin
            t.v = 1'b1; t.d = c[15-4*i -: 4]; t.rl = 1'b0; t.ps = 1'b0;
            t.exp = (i == 3) ? fin : mid;
            vq.push_back(t);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic saw_unl;

        // Sequential vector table: unlock, wrong try, programming, aborts, relock priorities
        add4(16'h1234, 7'b0000000, 7'b1000000);
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0));
        add4(16'h1934, 7'b0000000, 7'b0100001);
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1));
        vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'd1));   // prog_start ignored when locked
        add4(16'h1234, 7'b0000001, 7'b1000000);
        vq.push_back(mk(1, 9, 0, 0, 1, 0, 0, 0, 0, 2'd0));   // digits ignored when unlocked
        vq.push_back(mk(1, 9, 0, 0, 1, 0, 0, 0, 0, 2'd0));
        vq.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'd0));   // relock beats prog_start
        add4(16'h1234, 7'b0000000, 7'b1000000);
        vq.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 2'd0));
        add4(16'h5678, 7'b1010000, 7'b1001000);
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0));
        add4(16'h1234, 7'b0000000, 7'b0100001);
        add4(16'h5678, 7'b0000001, 7'b1000000);
        vq.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 2'd0));
        vq.push_back(mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 2'd0));
        vq.push_back(mk(1, 2, 0, 0, 1, 0, 1, 0, 0, 2'd0));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0));   // abort programming
        add4(16'h5678, 7'b0000000, 7'b1000000);
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0));
        vq.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 2'd0));
        vq.push_back(mk(1, 6, 0, 0, 0, 0, 0, 0, 0, 2'd0));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0));   // partial entry cleared
        add4(16'h5678, 7'b0000000, 7'b1000000);
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0));
        vq.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 2'd0));   // relock drops the digit
        vq.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 2'd0));
        vq.push_back(mk(1, 6, 0, 0, 0, 0, 0, 0, 0, 2'd0));
        vq.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 0, 2'd0));
        vq.push_back(mk(1, 8, 0, 0, 1, 0, 0, 0, 0, 2'd0));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_outputs", 32'(outs()), 32'd0);

        for (int i = 0; i < vq.size(); i++) begin
            valid = vq[i].v; digit = vq[i].d; relock = vq[i].rl; prog_start = vq[i].ps;
            tick();
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vq[i].exp));
        end
        valid = 1'b0; relock = 1'b0; prog_start = 1'b0;

        // Repeated lockouts without an intervening unlock (code is now 5678)
        for (int k = 0; k < 5; k++) begin
            for (int e = 0; e < 3; e++) begin
                enter4(16'h9999);
                chk($sformatf("lk%0d_wrong%0d", k, e), 32'(wrong_try_pulse), 32'd1);
                chk($sformatf("lk%0d_fail%0d", k, e), 32'(fail_count), 32'(e + 1));
                chk($sformatf("lk%0d_lockout%0d", k, e), 32'(lockout), 32'(e == 2));
            end
            n = 1;
            saw_unl = 1'b0;
            while (lockout && n < 3000) begin
                if (k == 0) begin
                    valid = 1'b1;
                    digit = 4'(5 + (n % 4));
                    relock = (n % 7 == 0);
                    prog_start = (n % 11 == 0);
                end
                tick();
                saw_unl |= unlocked;
                if (lockout) n++;
            end
            valid = 1'b0; relock = 1'b0; prog_start = 1'b0;
            chk($sformatf("lk%0d_len", k), 32'(n), 32'(exp_lock_len(k)));
            chk($sformatf("lk%0d_no_unlock", k), 32'(saw_unl), 32'd0);
            chk($sformatf("lk%0d_fail_clr", k), 32'(fail_count), 32'd0);
        end
        enter4(16'h5678);
        chk("post_lockout_unlock", 32'(outs()), 32'b1000000);

        // Auto-relock from a plain unlock
        n = 1;
        while (unlocked && n < 500) begin
            tick();
            if (unlocked) n++;
        end
        chk("autorelock_len", 32'(n), 32'd50);

        // Auto-relock restarts after returning from programming
        enter4(16'h5678);
        repeat (30) tick();
        chk("autorelock_still_open", 32'(unlocked), 32'd1);
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
        enter4(16'h4321);
        chk("prog_done", 32'(prog_done_pulse), 32'd1);
        n = 1;
        while (unlocked && n < 500) begin
            tick();
            if (unlocked) n++;
        end
        chk("autorelock_after_prog", 32'(n), 32'd50);
        enter4(16'h4321);
        chk("new_code_unlock", 32'(unlocked), 32'd1);
        relock = 1'b1;
        tick();
        relock = 1'b0;

        // Reset in the middle of a lockout restores the default code
        for (int e = 0; e < 3; e++) enter4(16'h9999);
        repeat (10) tick();
        chk("pre_reset_lockout", 32'(lockout), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 32'(outs()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        enter4(16'h4321);
        chk("reset_code_lost", 32'(outs()), 32'b0100001);
        enter4(16'h1234);
        chk("reset_default_unlock", 32'(outs()), 32'b1000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/code_lock_prog.md
# code_lock_prog

Parametrised successor to the fixed-code keypad lock. It collects a configurable-length code of configurable-width digits and compares the whole sequence only after the last digit, so a failure never reveals which digit was wrong. It adds a user-programmable code, an optional auto-relock timer and optional escalating lockout. It sits between the keypad debouncer/encoder (`digit`/`valid`) and the actuator/status logic.

## Interface
- `CODE_LEN`, 4: digits per code (≥1).
- `DIGIT_W`, 4: bits per digit.
- `DEFAULT_CODE`, 16'h1234: reset code, CODE_LEN*DIGIT_W bits, first digit in MSBs.
- `MAX_ATTEMPTS`, 3: consecutive wrong entries that trigger lockout (≥1).
- `LOCKOUT_CYCLES`, 1000: base lockout length in clocks (≥1).
- `AUTO_RELOCK_CYCLES`, 0: clocks in UNLOCKED before automatic relock; 0 disables.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `digit` in DIGIT_W: keypad digit, sampled when `valid`=1.
- `valid` in 1: one-cycle digit strobe.
- `relock` in 1: return to locked state.
- `prog_start` in 1: enter programming; honoured only in UNLOCKED.
- `unlocked` out 1: registered; high in UNLOCKED and PROG.
- `prog_mode` out 1: high in PROG.
- `wrong_try_pulse` out 1: one-cycle pulse per failed full entry.
- `prog_done_pulse` out 1: one-cycle pulse when a new code is committed.
- `lockout` out 1: high during lockout.
- `fail_count` out $clog2(MAX_ATTEMPTS+1): consecutive failures.

## Operation
- Reset values: state LOCKED, code register = DEFAULT_CODE, digit index 0, all outputs 0, escalation level 0.
- States and transitions:
  - LOCKED: each `valid` digit is shifted into the entry buffer and the index increments. On the CODE_LEN-th digit the full buffer is compared with the code register.
    - Match → UNLOCKED; `fail_count` is cleared and the escalation level is cleared.
    - Mismatch → `wrong_try_pulse` fires and `fail_count` increments. If `fail_count` reaches MAX_ATTEMPTS → LOCKOUT.
  - UNLOCKED: `valid` is ignored. `prog_start` → PROG. `relock`, or expiry of the auto-relock timer → LOCKED.
  - PROG: CODE_LEN digits are captured. After the last one the code register is written atomically, `prog_done_pulse` fires and the state returns to UNLOCKED. `relock` aborts: code unchanged → LOCKED.
  - LOCKOUT: `valid`, `relock` and `prog_start` are all ignored. The counter loads the lockout length and decrements. At 0 → LOCKED, with `fail_count` cleared and the entry index cleared.
- `relock` in LOCKED clears a partial entry. No failure is counted.
- Simultaneous events:
  - `relock` together with `valid`: relock wins and the digit is dropped.
  - `prog_start` together with `relock`: relock wins.
- The auto-relock counter restarts on every entry into UNLOCKED, including a return from PROG.

## Timing
- `unlocked` rises the clock after the edge that samples the final correct digit.
- `wrong_try_pulse` is high for exactly the clock after the edge that samples the final digit of a wrong entry.
- `lockout` rises in the same cycle as the MAX_ATTEMPTS-th `wrong_try_pulse`. It stays high for exactly the lockout length in clocks.
- `prog_done_pulse` fires the clock after the final programming digit. The new code is effective on the next entry.
- Auto-relock: `unlocked` falls exactly AUTO_RELOCK_CYCLES clocks after it rose.
- Counter widths are sized for the maximum lockout length, LOCKOUT_CYCLES*8, with no wrap.
- Reset asserted mid-operation (any state) returns all outputs to their reset values immediately. The programmed code is lost and DEFAULT_CODE is restored.

## Configuration
- `CODE_LOCK_ESCALATE_EN` defined:
  - Lockout length = LOCKOUT_CYCLES << level, where level (0..3) increments after each lockout and saturates at 3.
  - Level is cleared by a successful unlock or by reset.
- Not defined: every lockout lasts LOCKOUT_CYCLES and no level register exists.

## Structure
- Package `code_lock_pkg`:
  - state enum (LOCKED, UNLOCKED, PROG, LOCKOUT);
  - escalation-level width constant (2);
  - max-shift constant (3).
- Sub-module `code_lock_entry`:
  - digit shift buffer plus index counter, with a `done` strobe on the CODE_LEN-th digit and a `clear` input;
  - shared by entry and programming.
- The top level holds the FSM, the code register, the failure/lockout/auto-relock counters and the output registers.

## Test plan
Default parameters unless stated: LOCKOUT_CYCLES=80, DEFAULT_CODE=16'h1234.

1. Reset, push 1,2,3,4 → `unlocked`=1 one clock after the 4th `valid`; `fail_count`=0; no `wrong_try_pulse`.
2. Push 1,9,3,4 → no pulse after digits 1–3; a single `wrong_try_pulse` after digit 4; `fail_count`=1.
3. Three wrong entries (9,9,9,9 ×3) → `lockout` high for exactly 80 clocks; 1,2,3,4 pushed during lockout is ignored; afterwards `fail_count`=0 and 1,2,3,4 unlocks.
4. Unlock, `prog_start`, push 5,6,7,8 → `prog_done_pulse`; relock; 1,2,3,4 gives `wrong_try_pulse`; 5,6,7,8 unlocks. Repeat with `relock` after 2 programming digits → code unchanged.
5. AUTO_RELOCK_CYCLES=50 → `unlocked` falls 50 clocks after rising. `relock` with `valid`=1 in the same cycle → digit dropped and the entry index stays 0.
6. With CODE_LOCK_ESCALATE_EN: first lockout 80 clocks, second 160, fourth and fifth 640. Assert `rst` mid-lockout → `lockout`=0 immediately and 1,2,3,4 unlocks.
